// File: rtl/uart_tx_controller_pkg.sv
// Shared definitions for the UART transmit frame sequencer.
package uart_tx_controller_pkg;

   // Frame sequencing states, fixed 3-bit encoding.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;

   localparam int unsigned DEFAULT_OVERSAMPLE = 16;

   // Parity-mode selectors for PARITY_ODD.
   localparam int unsigned PAR_EVEN = 0;
   localparam int unsigned PAR_ODD  = 1;

   // Level of the serial line while idle and during stop bits.
   localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_tx_shift_reg.sv
// Holds the word in flight plus its parity bit; shifts LSB-first on request.
module uart_tx_shift_reg
   import uart_tx_controller_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned PARITY_ODD = PAR_EVEN
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  load,
   input  logic                  shift,
   input  logic [DATA_WIDTH-1:0] load_data,
   output logic                  cur_bit,
   output logic                  next_bit,
   output logic                  parity_bit
);

   localparam logic ODD_SENSE = (PARITY_ODD == PAR_ODD);

   logic [DATA_WIDTH-1:0] sreg_q;
   logic                  parity_q;

   // Load captures the word and its parity together; shift drops the sent LSB.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sreg_q   <= '0;
         parity_q <= 1'b0;
      end else if (load) begin
         sreg_q   <= load_data;
         parity_q <= (^load_data) ^ ODD_SENSE;
      end else if (shift) begin
         sreg_q   <= {1'b0, sreg_q[DATA_WIDTH-1:1]};
      end
   end

   // next_bit lets the FSM register the following data bit on the same edge it shifts.
   assign cur_bit    = sreg_q[0];
   assign next_bit   = sreg_q[1];
   assign parity_bit = parity_q;

endmodule

// File: rtl/uart_tx_controller.sv
// UART transmit frame sequencer: start, data LSB-first, optional parity, stop.
module uart_tx_controller
   import uart_tx_controller_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE,
   parameter int unsigned PARITY_EN  = 1,
   parameter int unsigned PARITY_ODD = PAR_EVEN,
   parameter int unsigned STOP_BITS  = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  sample_ENABLE,
   input  logic                  tx_en,
   input  logic                  tx_wr,
   input  logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_out,
   output logic                  tx_busy,
   output logic                  tx_done
);

   localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
   localparam int unsigned BIT_W  = $clog2(DATA_WIDTH);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
   localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

   tx_state_e         state_q, state_d;
   logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
   logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic              tx_out_q, tx_out_d;
   logic              tx_busy_q, tx_busy_d;
   logic              tx_done_q, tx_done_d;
   logic              sr_load, sr_shift;
   logic              sr_cur, sr_next, sr_parity;

   uart_tx_shift_reg #(
      .DATA_WIDTH (DATA_WIDTH),
      .PARITY_ODD (PARITY_ODD)
   ) u_shift_reg (
      .clock      (clock),
      .reset      (reset),
      .load       (sr_load),
      .shift      (sr_shift),
      .load_data  (tx_data),
      .cur_bit    (sr_cur),
      .next_bit   (sr_next),
      .parity_bit (sr_parity)
   );

   // State, counters and registered outputs; reset returns the line high at once.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         tx_out_q   <= LINE_IDLE;
         tx_busy_q  <= 1'b0;
         tx_done_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         tx_out_q   <= tx_out_d;
         tx_busy_q  <= tx_busy_d;
         tx_done_q  <= tx_done_d;
      end
   end

   // Next-state: accept in IDLE, otherwise advance one bit every OVERSAMPLE ticks.
   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      tx_out_d   = tx_out_q;
      tx_busy_d  = tx_busy_q;
      tx_done_d  = 1'b0;
      sr_load    = 1'b0;
      sr_shift   = 1'b0;

      if (state_q == IDLE) begin
         tx_out_d  = LINE_IDLE;
         tx_busy_d = 1'b0;
         // Accept wins over a coincident tick: the counter restarts from zero.
         if (tx_wr && tx_en) begin
            state_d    = START;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            tx_out_d   = 1'b0;
            tx_busy_d  = 1'b1;
            sr_load    = 1'b1;
         end
      end else if (sample_ENABLE) begin
         if (tick_cnt_q != TICK_LAST) begin
            tick_cnt_d = tick_cnt_q + 1'b1;
         end else begin
            tick_cnt_d = '0;
            unique case (state_q)
               START: begin
                  state_d   = DATA;
                  bit_cnt_d = '0;
                  tx_out_d  = sr_cur;
               end
               DATA: begin
                  if (bit_cnt_q == DATA_LAST) begin
                     bit_cnt_d = '0;
                     if (PARITY_EN != 0) begin
                        state_d  = PARITY;
                        tx_out_d = sr_parity;
                     end else begin
                        state_d  = STOP;
                        tx_out_d = LINE_IDLE;
                     end
                  end else begin
                     bit_cnt_d = bit_cnt_q + 1'b1;
                     tx_out_d  = sr_next;
                     sr_shift  = 1'b1;
                  end
               end
               PARITY: begin
                  state_d   = STOP;
                  bit_cnt_d = '0;
                  tx_out_d  = LINE_IDLE;
               end
               STOP: begin
                  // bit_cnt is reused to count stop bits.
                  if (bit_cnt_q == STOP_LAST) begin
                     state_d   = IDLE;
                     bit_cnt_d = '0;
                     tx_busy_d = 1'b0;
                     tx_done_d = 1'b1;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 1'b1;
                  end
               end
               default: begin
                  state_d   = IDLE;
                  tx_out_d  = LINE_IDLE;
                  tx_busy_d = 1'b0;
               end
            endcase
         end
      end
   end

   assign tx_out  = tx_out_q;
   assign tx_busy = tx_busy_q;
   assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_tx_controller.sv
// Directed bench for uart_tx_controller: four parameterisations share clock and tick.
module tb_uart_tx_controller;

   typedef struct {
      logic [15:0] bits;
      int          n;
   } frame_t;

   logic       clock = 1'b0;
   logic       reset;
   logic       sample_ENABLE = 1'b0;
   logic       tick_gate;
   int         div = 0;
   logic       tx_en;
   logic [7:0] tx_data;
   logic [3:0] wr;
   logic [3:0] out_v, busy_v, done_v;
   logic [1:0] sel;
   logic       mon_out, mon_busy, mon_done;
   int         checks = 0;
   int         errors = 0;
   int         miss;
   frame_t     exp_q[$];
   frame_t     dropped;

   always #5 clock = ~clock;

   // Oversample tick every 4 clocks, updated just after the rising edge.
   always @(posedge clock) begin
      #1;
      div = (div == 3) ? 0 : div + 1;
      sample_ENABLE = tick_gate && (div == 0);
   end

   assign mon_out  = out_v[sel];
   assign mon_busy = busy_v[sel];
   assign mon_done = done_v[sel];

   uart_tx_controller #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_e (
      .clock (clock), .reset (reset), .sample_ENABLE (sample_ENABLE), .tx_en (tx_en),
      .tx_wr (wr[0]), .tx_data (tx_data), .tx_out (out_v[0]), .tx_busy (busy_v[0]),
      .tx_done (done_v[0]));
   uart_tx_controller #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_o (
      .clock (clock), .reset (reset), .sample_ENABLE (sample_ENABLE), .tx_en (tx_en),
      .tx_wr (wr[1]), .tx_data (tx_data), .tx_out (out_v[1]), .tx_busy (busy_v[1]),
      .tx_done (done_v[1]));
   uart_tx_controller #(.PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_n (
      .clock (clock), .reset (reset), .sample_ENABLE (sample_ENABLE), .tx_en (tx_en),
      .tx_wr (wr[2]), .tx_data (tx_data), .tx_out (out_v[2]), .tx_busy (busy_v[2]),
      .tx_done (done_v[2]));
   uart_tx_controller #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_s2 (
      .clock (clock), .reset (reset), .sample_ENABLE (sample_ENABLE), .tx_en (tx_en),
      .tx_wr (wr[3]), .tx_data (tx_data), .tx_out (out_v[3]), .tx_busy (busy_v[3]),
      .tx_done (done_v[3]));

   // Reference frame: start, data LSB-first, parity if enabled, stop bit(s) as trailing ones.
   function automatic frame_t build_frame(input logic [1:0] s, input logic [7:0] d);
      frame_t f;
      logic   par;
      int     stops;
      stops = (s == 2'd3) ? 2 : 1;
      par   = (^d) ^ (s == 2'd1);
      if (s != 2'd2) begin
         f.bits = {6'h3F, par, d, 1'b0};
         f.n    = 10 + stops;
      end else begin
         f.bits = {7'h7F, d, 1'b0};
         f.n    = 9 + stops;
      end
      return f;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
      end
   endtask

   // Write one word to DUT s at the current falling edge; expect the start bit next edge.
   task automatic send(input logic [1:0] s, input logic [7:0] d);
      sel     = s;
      tx_data = d;
      wr      = '0;
      wr[s]   = 1'b1;
      exp_q.push_back(build_frame(s, d));
      @(negedge clock);
      wr = '0;
      check("accept_line", 32'(mon_out), 32'd0);
      check("accept_busy", 32'(mon_busy), 32'd1);
   endtask

   // Pop the expected frame and check the line before every tick, one check per bit.
   task automatic capture(input int inject_at, input int stall_at);
      frame_t     f;
      int         j, guard, total, bad_line, bad_ctl, hold;
      logic [3:0] bi;
      bit         stalled;
      if (exp_q.size() == 0) begin
         check("scoreboard_empty", 32'd1, 32'd0);
         return;
      end
      f        = exp_q.pop_front();
      total    = f.n * 16;
      j        = 0;
      guard    = 0;
      bad_line = 0;
      bad_ctl  = 0;
      stalled  = 1'b0;
      while (j < total && guard < total * 4 + 400) begin
         wr = '0;
         if (j == inject_at) begin
            tx_data = ~tx_data;
            wr[sel] = 1'b1;
         end
         if (sample_ENABLE) begin
            bi = 4'(j / 16);
            if (mon_out !== f.bits[bi]) bad_line++;
            if (mon_busy !== 1'b1 || mon_done !== 1'b0) bad_ctl++;
            if (j % 16 == 15) begin
               check($sformatf("bit%0d_line", j / 16), 32'(bad_line), 32'd0);
               check($sformatf("bit%0d_ctl", j / 16), 32'(bad_ctl), 32'd0);
               bad_line = 0;
               bad_ctl  = 0;
            end
            j++;
         end
         if (j == stall_at && !stalled) begin
            stalled   = 1'b1;
            tick_gate = 1'b0;
            wr        = '0;
            bi        = 4'(j / 16);
            hold      = 0;
            repeat (100) begin
               @(negedge clock);
               if (mon_out !== f.bits[bi] || mon_busy !== 1'b1) hold++;
            end
            check("stall_hold", 32'(hold), 32'd0);
            tick_gate = 1'b1;
         end
         @(negedge clock);
         guard++;
      end
      wr = '0;
      if (j < total) check("frame_timeout", 32'(j), 32'(total));
      check("done_pulse", 32'(mon_done), 32'd1);
      check("done_busy", 32'(mon_busy), 32'd0);
      check("done_line", 32'(mon_out), 32'd1);
   endtask

   initial begin
      reset     = 1'b0;
      wr        = '0;
      tx_en     = 1'b1;
      tx_data   = '0;
      sel       = '0;
      tick_gate = 1'b1;
      repeat (3) @(negedge clock);
      check("reset_line", 32'(out_v), 32'hF);
      check("reset_busy", 32'(busy_v), 32'h0);
      check("reset_done", 32'(done_v), 32'h0);
      reset = 1'b1;
      repeat (5) @(negedge clock);

      // 8E1 0xA5, then a back-to-back frame written in the tx_done cycle with a mid-frame write.
      send(2'd0, 8'hA5);
      capture(-1, -1);
      send(2'd0, 8'hC3);
      capture(150, -1);
      @(negedge clock);
      check("done_clear", 32'(done_v[0]), 32'd0);

      // Write with tx_en low is ignored.
      tx_en   = 1'b0;
      tx_data = 8'h77;
      wr[0]   = 1'b1;
      @(negedge clock);
      wr   = '0;
      miss = 0;
      repeat (20) begin
         if (out_v[0] !== 1'b1 || busy_v[0] !== 1'b0) miss++;
         @(negedge clock);
      end
      check("en_low_ignored", 32'(miss), 32'd0);
      tx_en = 1'b1;

      // Odd parity, then no parity.
      send(2'd1, 8'h01);
      capture(-1, -1);
      @(negedge clock);
      send(2'd1, 8'h00);
      capture(-1, -1);
      @(negedge clock);
      send(2'd2, 8'h00);
      capture(-1, -1);
      @(negedge clock);

      // Asynchronous reset while in DATA (bit 0 of 0x5A is 0), then a fresh frame.
      send(2'd0, 8'h5A);
      repeat (100) @(negedge clock);
      check("pre_reset_line", 32'(out_v[0]), 32'd0);
      check("pre_reset_busy", 32'(busy_v[0]), 32'd1);
      #2 reset = 1'b0;
      #1;
      check("async_reset_line", 32'(out_v[0]), 32'd1);
      check("async_reset_busy", 32'(busy_v[0]), 32'd0);
      check("async_reset_done", 32'(done_v[0]), 32'd0);
      dropped = exp_q.pop_front();
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      send(2'd0, 8'h3C);
      capture(-1, -1);
      @(negedge clock);

      // Two stop bits with a 100-clock tick stall mid-bit.
      send(2'd3, 8'hFF);
      capture(-1, 40);
      @(negedge clock);
      check("s2_done_clear", 32'(done_v[3]), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
